// File: rtl/cv32e40p_pkg.sv
// Shared types for the fault-tolerant decoder support logic.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RETRY = 2'd1,
    WAIT  = 2'd2,
    ALARM = 2'd3
  } ft_mgr_state_e;

endpackage

// File: rtl/cv32e40p_ft_leaky_bucket.sv
// Leaky-bucket fault-rate score: +1 per event, -1 per leak period, flags when
// the upcoming score sits at THRESHOLD so escalation lands one cycle after the event.
module cv32e40p_ft_leaky_bucket #(
  parameter int unsigned THRESHOLD   = 4,
  parameter int unsigned LEAK_PERIOD = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic event_i,
  output logic at_threshold_c
);

  localparam int unsigned SW = $clog2(THRESHOLD + 1);
  localparam int unsigned TW = $clog2(LEAK_PERIOD);

  logic [SW-1:0] score_q, score_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          leak;

  always_comb begin
    leak    = (timer_q == TW'(LEAK_PERIOD - 1));
    timer_d = leak ? '0 : timer_q + TW'(1);
    score_d = score_q;
    if (clear_i) begin
      score_d = '0;
      timer_d = '0;
    end else if (event_i && !leak) begin
      if (score_q != SW'(THRESHOLD)) score_d = score_q + SW'(1);
    end else if (leak && !event_i) begin
      if (score_q != '0) score_d = score_q - SW'(1);
    end
    at_threshold_c = (score_d == SW'(THRESHOLD));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      timer_q <= '0;
    end else begin
      score_q <= score_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/cv32e40p_ft_fault_manager.sv
// Retry/escalation sequencer for the TMR voter fault flags around the
// compressed decoder: stalls IF/ID, re-fetches, and raises a sticky alarm.
module cv32e40p_ft_fault_manager
  import cv32e40p_pkg::*;
#(
  parameter int unsigned N_SRC       = 3,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned THRESHOLD   = 4,
  parameter int unsigned LEAK_PERIOD = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [N_SRC-1:0] fault_i,
  output logic             retry_req_o,
  input  logic             retry_ack_i,
  output logic             stall_o,
  output logic             alarm_o,
  output logic [CNT_W-1:0] fault_cnt_o,
  output logic [N_SRC-1:0] first_src_o,
  input  logic             clear_i
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  ft_mgr_state_e    state_q, state_d;
  logic [RW-1:0]    retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0] fault_cnt_q;
  logic [N_SRC-1:0] first_src_q;
  logic             fault_event;
  logic             event_acc;
  logic             at_threshold;

  // Faults are only meaningful while a fresh or re-decoded word is consumed.
  assign fault_event = valid_i & (|fault_i) & ((state_q == IDLE) | (state_q == WAIT));
  assign event_acc   = fault_event & ~clear_i;

  cv32e40p_ft_leaky_bucket #(
    .THRESHOLD  (THRESHOLD),
    .LEAK_PERIOD(LEAK_PERIOD)
  ) u_bucket (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear_i),
    .event_i       (event_acc),
    .at_threshold_c(at_threshold)
  );

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    if (clear_i) begin
      state_d     = IDLE;
      retry_cnt_d = '0;
    end else if (at_threshold) begin
      state_d = ALARM;
    end else begin
      case (state_q)
        IDLE: begin
          if (fault_event) begin
            if (MAX_RETRY == 0) begin
              state_d = ALARM;
            end else begin
              state_d     = RETRY;
              retry_cnt_d = RW'(1);
            end
          end
        end
        RETRY: begin
          if (retry_ack_i) state_d = WAIT;
        end
        WAIT: begin
          if (valid_i) begin
            if (|fault_i) begin
              if (retry_cnt_q == RW'(MAX_RETRY)) begin
                state_d = ALARM;
              end else begin
                state_d     = RETRY;
                retry_cnt_d = retry_cnt_q + RW'(1);
              end
            end else begin
              state_d     = IDLE;
              retry_cnt_d = '0;
            end
          end
        end
        ALARM:   state_d = ALARM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  // Lifetime statistics: saturating count and sticky first-fault snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt_q <= '0;
      first_src_q <= '0;
    end else if (clear_i) begin
      fault_cnt_q <= '0;
      first_src_q <= '0;
    end else if (event_acc) begin
      if (fault_cnt_q != '1) fault_cnt_q <= fault_cnt_q + CNT_W'(1);
      if (first_src_q == '0) first_src_q <= fault_i;
    end
  end

  assign retry_req_o = (state_q == RETRY);
  assign alarm_o     = (state_q == ALARM);
  assign stall_o     = (state_q != IDLE) | fault_event;
  assign fault_cnt_o = fault_cnt_q;
  assign first_src_o = first_src_q;

endmodule

// File: tb/tb_cv32e40p_ft_fault_manager.sv
// Scoreboard bench for the fault manager against a transaction-level model.
module tb_cv32e40p_ft_fault_manager;

  localparam int LP   = 1024;
  localparam int TH   = 4;
  localparam int MR   = 2;
  localparam int CMAX = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_i = 1'b0;
  logic [2:0] fault_i = 3'b000;
  logic       retry_ack_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       retry_req_o, stall_o, alarm_o;
  logic [7:0] fault_cnt_o;
  logic [2:0] first_src_o;

  cv32e40p_ft_fault_manager #(
    .N_SRC(3), .MAX_RETRY(MR), .CNT_W(8), .THRESHOLD(TH), .LEAK_PERIOD(LP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .fault_i    (fault_i),
    .retry_req_o(retry_req_o),
    .retry_ack_i(retry_ack_i),
    .stall_o    (stall_o),
    .alarm_o    (alarm_o),
    .fault_cnt_o(fault_cnt_o),
    .first_src_o(first_src_o),
    .clear_i    (clear_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit retry;
    bit stall;
    bit alarm;
    int cnt;
    int first;
  } exp_t;

  typedef enum {M_IDLE, M_REQ, M_WAIT, M_ALARM} mode_e;

  exp_t  q[$];
  exp_t  mon_e;
  mode_e mode;
  int    attempts, score, cnt, first, tick;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mode = M_IDLE; attempts = 0; score = 0; cnt = 0; first = 0; tick = 0;
  endfunction

  // One clock of stimulus; the model predicts this cycle's outputs, then advances.
  task automatic cyc(input bit v, input bit [2:0] f, input bit ack, input bit clr);
    exp_t e;
    bit   evt, leak;
    @(posedge clk); #1;
    valid_i = v; fault_i = f; retry_ack_i = ack; clear_i = clr;
    evt     = v && (f != 0) && (mode == M_IDLE || mode == M_WAIT);
    e.retry = (mode == M_REQ);
    e.stall = (mode != M_IDLE) || evt;
    e.alarm = (mode == M_ALARM);
    e.cnt   = cnt;
    e.first = first;
    q.push_back(e);
    if (clr) begin
      model_reset();
    end else begin
      leak = ((tick % LP) == LP - 1);
      tick++;
      if (evt && !leak) score = (score + 1 > TH) ? TH : score + 1;
      else if (leak && !evt && score > 0) score--;
      if (evt) begin
        if (cnt < CMAX) cnt++;
        if (first == 0) first = f;
      end
      if (score >= TH) mode = M_ALARM;
      else case (mode)
        M_IDLE: if (evt) begin
          if (MR == 0) mode = M_ALARM;
          else begin mode = M_REQ; attempts = 1; end
        end
        M_REQ: if (ack) mode = M_WAIT;
        M_WAIT: if (v) begin
          if (f != 0) begin
            if (attempts == MR) mode = M_ALARM;
            else begin mode = M_REQ; attempts++; end
          end else begin
            mode = M_IDLE; attempts = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  // One fault, acked after a random delay, then a clean re-decode.
  task automatic transient(input bit [2:0] f);
    cyc(1'b1, f, 1'b0, 1'b0);
    idle($urandom_range(0, 3));
    cyc(1'b0, 3'b000, 1'b1, 1'b0);
    idle($urandom_range(0, 2));
    cyc(1'b1, 3'b000, 1'b0, 1'b0);
    idle($urandom_range(0, 2));
  endtask

  task automatic spot(input string name, input int act_sel, input int exp);
    @(negedge clk);
    case (act_sel)
      0: chk(name, retry_req_o, exp);
      1: chk(name, stall_o, exp);
      2: chk(name, alarm_o, exp);
      3: chk(name, fault_cnt_o, exp);
      default: chk(name, first_src_o, exp);
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      mon_e = q.pop_front();
      chk("retry_req", retry_req_o, mon_e.retry);
      chk("stall", stall_o, mon_e.stall);
      chk("alarm", alarm_o, mon_e.alarm);
      chk("fault_cnt", fault_cnt_o, mon_e.cnt);
      chk("first_src", first_src_o, mon_e.first);
    end
  end

  initial begin
    model_reset();
    #1;
    chk("rst_retry", retry_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_alarm", alarm_o, 0);
    chk("rst_cnt", fault_cnt_o, 0);
    chk("rst_first", first_src_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Single transient
    transient(3'b001);
    spot("t1_cnt", 3, 1);
    spot("t1_first", 4, 1);
    spot("t1_alarm", 2, 0);
    spot("t1_stall", 1, 0);

    // Persistent fault exhausts both retries
    cyc(1'b0, 3'b000, 1'b0, 1'b1);
    cyc(1'b1, 3'b010, 1'b0, 1'b0);
    repeat (2) begin
      idle($urandom_range(0, 3));
      cyc(1'b0, 3'b000, 1'b1, 1'b0);
      idle($urandom_range(0, 2));
      cyc(1'b1, 3'($urandom_range(1, 7)), 1'b0, 1'b0);
    end
    idle(3);
    spot("pers_alarm", 2, 1);
    spot("pers_stall", 1, 1);
    spot("pers_cnt", 3, 3);
    spot("pers_first", 4, 2);

    // Clear in ALARM with a concurrent event: event discarded
    cyc(1'b1, 3'b101, 1'b0, 1'b1);
    idle(1);
    spot("clr_alarm", 2, 0);
    spot("clr_cnt", 3, 0);
    spot("clr_first", 4, 0);

    // Rate escalation: four quick transients
    for (int i = 0; i < 4; i++) transient(3'($urandom_range(1, 7)));
    idle(1);
    spot("rate_alarm", 2, 1);
    spot("rate_cnt", 3, 4);

    // Leak: two events, long idle, three events -> no alarm
    cyc(1'b0, 3'b000, 1'b0, 1'b1);
    transient(3'b100);
    transient(3'b100);
    idle(2 * LP);
    for (int i = 0; i < 3; i++) transient(3'b011);
    spot("leak_alarm", 2, 0);

    // Event coincident with leak expiry leaves score at 3
    cyc(1'b0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) transient(3'b001);
    while ((tick % LP) != LP - 1) idle(1);
    transient(3'b110);
    spot("coinc_alarm", 2, 0);
    transient(3'b110);
    spot("coinc_next_alarm", 2, 1);

    // Randomized traffic
    cyc(1'b0, 3'b000, 1'b0, 1'b1);
    repeat (3000) begin
      cyc(1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 199) == 0));
    end

    // Async reset while a retry request is outstanding
    cyc(1'b0, 3'b000, 1'b0, 1'b1);
    cyc(1'b1, 3'b001, 1'b0, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_retry", retry_req_o, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_alarm", alarm_o, 0);
    chk("arst_cnt", fault_cnt_o, 0);
    chk("arst_first", first_src_o, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    transient(3'b010);
    spot("post_rst_cnt", 3, 1);
    spot("post_rst_first", 4, 2);

    idle(2);
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cv32e40p_ft_fault_manager.md
# cv32e40p_ft_fault_manager

Sequencer for the fault-detect flags produced by the TMR voters around the triplicated compressed decoder. On a disagreement it stalls IF/ID, requests a re-fetch/re-decode of the same instruction, and retries up to a bounded count. Persistent or too-frequent faults escalate to a sticky alarm. It sits beside the fault-tolerant decoder wrapper and talks to the IF stage (stall, retry handshake) and to the controller/debug logic (alarm, statistics).

## Interface
- N_SRC, 3: number of voter `detected` flags monitored (instr, is_compressed, illegal_instr).
- MAX_RETRY, 2: re-decode attempts allowed per faulting instruction; 0 means escalate immediately.
- CNT_W, 8: width of the lifetime fault counter.
- THRESHOLD, 4: leaky-bucket score at which the alarm fires (≥1).
- LEAK_PERIOD, 1024: cycles between score decrements (≥2).
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  decoder output is being consumed this cycle; fault_i is only evaluated when high.
- fault_i  in  N_SRC  per-voter `detected` flags.
- retry_req_o  out  1  request the IF stage to re-present the current instruction.
- retry_ack_i  in  1  IF stage accepted the retry request.
- stall_o  out  1  hold IF/ID; also blocks ID from consuming the decoded word.
- alarm_o  out  1  sticky permanent-fault indication.
- fault_cnt_o  out  CNT_W  saturating count of fault events since reset/clear.
- first_src_o  out  N_SRC  snapshot of fault_i at the first event since reset/clear.
- clear_i  in  1  clears alarm, counter, score, snapshot; FSM returns to IDLE.

## Operation
- Fault event: valid_i & |fault_i while in IDLE or WAIT. Ignored in RETRY and ALARM.
- FSM states:
  - IDLE: on event, go to RETRY with retry_cnt=1; if MAX_RETRY==0, go to ALARM.
  - RETRY: retry_req_o=1 and held until retry_ack_i; on ack, go to WAIT.
  - WAIT: wait for valid_i. Faulty and retry_cnt==MAX_RETRY → ALARM. Faulty otherwise → RETRY with retry_cnt+1. Clean → IDLE with retry_cnt=0.
  - ALARM: terminal until clear_i.
- stall_o = (state≠IDLE) | (state==IDLE & event). It is 1 in ALARM and 0 only in a clean IDLE cycle.
- fault_cnt: +1 per event, saturates at 2^CNT_W−1 and never wraps.
- first_src: captured on the first event while the value is zero. Later events do not change it.
- Score (leaky bucket):
  - +1 per event, saturating at THRESHOLD.
  - −1 when the leak timer expires, floor 0.
  - Event and leak in the same cycle leave the score unchanged.
  - Leak timer free-runs from 0 to LEAK_PERIOD−1 and wraps.
  - When the score reaches THRESHOLD, the next state is ALARM from any state. This has priority over the retry transitions.
- Priority: rst > clear_i > score alarm > normal FSM transitions.
- clear_i: state→IDLE; retry_cnt, score, leak timer, fault_cnt and first_src → 0; alarm_o→0. An event in the same cycle as clear_i is discarded.

## Timing
- Reset values: retry_req_o=0, stall_o=0 (given valid_i=0), alarm_o=0, fault_cnt_o=0, first_src_o=0, state=IDLE.
- stall_o is combinational from valid_i/fault_i in IDLE (same cycle as the event). It is registered-state driven otherwise.
- retry_req_o is driven from state. It asserts the cycle after the event and deasserts the cycle after retry_ack_i.
- retry_ack_i in the same cycle retry_req_o rises counts as acceptance.
- alarm_o asserts the cycle after the escalating event (registered) and stays high until clear_i or rst.
- fault_cnt_o and first_src_o update the cycle after the event.
- Async reset mid-retry drops retry_req_o and stall_o immediately. The IF stage must tolerate a withdrawn request.

## Structure
- cv32e40p_pkg gets a `ft_mgr_state_e` enum: IDLE, RETRY, WAIT, ALARM.
- Sub-module cv32e40p_ft_leaky_bucket holds the score, the leak timer, the saturation logic and the `at_threshold` output. Parameters: THRESHOLD, LEAK_PERIOD.
- The top level holds the FSM, retry counter, fault counter and snapshot register.

## Test plan
- Single transient: one event with fault_i=3'b001, clean re-decode after ack → stall_o same cycle, one retry_req pulse, back to IDLE; fault_cnt_o=1, first_src_o=001, alarm_o=0.
- Persistent fault, MAX_RETRY=2: every valid_i faulty → two retry handshakes, then alarm_o=1, stall_o stuck at 1; fault_cnt_o=3.
- Rate escalation: THRESHOLD=4, four isolated transients within 100 cycles, each cleared by one retry → alarm_o=1 after the 4th event.
- Leak: two events, idle 2×LEAK_PERIOD cycles, then three events → no alarm (score ≤3). Event coincident with leak expiry leaves the score unchanged.
- clear_i in ALARM concurrent with a fault event → IDLE; all statistics 0; event not counted.
- Async rst asserted while retry_req_o=1 and retry_ack_i withheld → all outputs at reset values immediately; normal operation after release.
